// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, square type and the move sequencer state encoding.
package chess_pkg;

    localparam logic [3:0] PIECE_EMPTY = 4'h0;
    localparam logic [3:0] WHITE_FIRST = 4'h1;
    localparam logic [3:0] WHITE_LAST  = 4'h6;
    localparam logic [3:0] BLACK_FIRST = 4'h7;
    localparam logic [3:0] BLACK_LAST  = 4'hC;
    localparam logic [3:0] HIGHLIGHT   = 4'hD;

    typedef logic [5:0] square_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CHECK,
        SEQ_PICK,
        SEQ_GAP,
        SEQ_PLACE,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/board_square_lookup.sv
// Returns the 4-bit piece code stored at one square of the flattened board.
module board_square_lookup #(
    parameter int SQ_W = 6
) (
    input  logic [255:0]    board_flat,
    input  logic [SQ_W-1:0] square,
    output logic [3:0]      code
);

    assign code = board_flat[{square, 2'b00} +: 4];

endmodule

// File: rtl/move_sequencer.sv
// Turns one accepted remote move into pick/place pulses for chess_board;
// passes the mouse commands straight through while idle.
module move_sequencer #(
    parameter int GAP_CYCLES = 1,
    parameter int SQ_W       = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            move_valid,
    output logic            move_ready,
    input  logic [SQ_W-1:0] move_from,
    input  logic [SQ_W-1:0] move_to,
    input  logic [255:0]    board_flat,
    input  logic [SQ_W-1:0] local_pos,
    input  logic            local_pick,
    input  logic            local_place,
    output logic [SQ_W-1:0] figure_position,
    output logic            pick_piece,
    output logic            place_piece,
    output logic [3:0]      captured_code,
    output logic            move_done,
    output logic            move_err
);
    import chess_pkg::*;

    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    seq_state_t      state;
    seq_state_t      next_state;
    logic [SQ_W-1:0] from_sq;
    logic [SQ_W-1:0] to_sq;
    logic [3:0]      from_code;
    logic [3:0]      to_code;
    logic [CNT_W-1:0] gap_cnt;
    logic            gap_last;
    logic            accept;
    logic            move_bad;

    board_square_lookup #(.SQ_W(SQ_W)) u_from_lookup (
        .board_flat (board_flat),
        .square     (from_sq),
        .code       (from_code)
    );

    board_square_lookup #(.SQ_W(SQ_W)) u_to_lookup (
        .board_flat (board_flat),
        .square     (to_sq),
        .code       (to_code)
    );

    assign accept   = move_valid && (state == SEQ_IDLE);
    assign move_bad = (from_sq == to_sq) || (from_code == PIECE_EMPTY);
    assign gap_last = (gap_cnt == CNT_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEQ_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Move operands, capture result, reject pulse and the pick-to-place spacing counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            from_sq       <= '0;
            to_sq         <= '0;
            captured_code <= '0;
            move_err      <= 1'b0;
            gap_cnt       <= '0;
        end else begin
            if (accept) begin
                from_sq <= move_from;
                to_sq   <= move_to;
            end
            if (state == SEQ_CHECK && !move_bad) begin
                captured_code <= to_code;
            end
            move_err <= (state == SEQ_CHECK) && move_bad;
            if (state == SEQ_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SEQ_IDLE:  if (accept) next_state = SEQ_CHECK;
            SEQ_CHECK: next_state = move_bad ? SEQ_IDLE : SEQ_PICK;
            SEQ_PICK:  next_state = SEQ_GAP;
            SEQ_GAP:   if (gap_last) next_state = SEQ_PLACE;
            SEQ_PLACE: next_state = SEQ_DONE;
            SEQ_DONE:  next_state = SEQ_IDLE;
            default:   next_state = SEQ_IDLE;
        endcase
    end

    // Outside IDLE the move owns the board, so mouse requests are dropped.
    always_comb begin
        move_ready      = 1'b0;
        figure_position = '0;
        pick_piece      = 1'b0;
        place_piece     = 1'b0;
        move_done       = 1'b0;
        case (state)
            SEQ_IDLE: begin
                move_ready      = 1'b1;
                figure_position = local_pos;
                pick_piece      = local_pick;
                place_piece     = local_place;
            end
            SEQ_PICK: begin
                figure_position = from_sq;
                pick_piece      = 1'b1;
            end
            SEQ_GAP: begin
                figure_position = from_sq;
            end
            SEQ_PLACE: begin
                figure_position = to_sq;
                place_piece     = 1'b1;
            end
            SEQ_DONE: begin
                move_done = 1'b1;
            end
            default: begin
                move_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: table of directed moves, hand-written
// corner sequences and randomized moves against a cycle-timeline model.
module tb_move_sequencer;

    localparam int G = 2;

    typedef struct packed {
        logic       ready;
        logic       pick;
        logic       place;
        logic       done;
        logic       err;
        logic [5:0] pos;
    } obs_t;

    typedef struct {
        string      name;
        logic [5:0] from;
        logic [5:0] to;
        logic [3:0] fromCode;
        logic [3:0] toCode;
        logic       expErr;
        logic [3:0] expCap;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         move_valid;
    logic         move_ready;
    logic [5:0]   move_from;
    logic [5:0]   move_to;
    logic [255:0] board_flat;
    logic [5:0]   local_pos;
    logic         local_pick;
    logic         local_place;
    logic [5:0]   figure_position;
    logic         pick_piece;
    logic         place_piece;
    logic [3:0]   captured_code;
    logic         move_done;
    logic         move_err;

    logic [3:0]   boardModel [64];
    int           checks = 0;
    int           fails  = 0;

    always #5 clk = ~clk;

    move_sequencer #(.GAP_CYCLES(G), .SQ_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .move_valid      (move_valid),
        .move_ready      (move_ready),
        .move_from       (move_from),
        .move_to         (move_to),
        .board_flat      (board_flat),
        .local_pos       (local_pos),
        .local_pick      (local_pick),
        .local_place     (local_place),
        .figure_position (figure_position),
        .pick_piece      (pick_piece),
        .place_piece     (place_piece),
        .captured_code   (captured_code),
        .move_done       (move_done),
        .move_err        (move_err)
    );

    task automatic setBoard();
        for (int s = 0; s < 64; s++) board_flat[4*s +: 4] = boardModel[s];
    endtask

    task automatic clearBoard();
        for (int s = 0; s < 64; s++) boardModel[s] = 4'h0;
    endtask

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [5:0] t,
                                 input logic [5:0] lpos, input logic lpick, input logic lplace);
        @(negedge clk);
        move_valid  = v;
        move_from   = f;
        move_to     = t;
        local_pos   = lpos;
        local_pick  = lpick;
        local_place = lplace;
        #2;
    endtask

    task automatic checkOutput(input string name, input int k, input obs_t exp);
        obs_t got;
        got = {move_ready, pick_piece, place_piece, move_done, move_err, figure_position};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s k=%0d got rdy=%b pick=%b place=%b done=%b err=%b pos=%0d expected rdy=%b pick=%b place=%b done=%b err=%b pos=%0d",
                     name, k, got.ready, got.pick, got.place, got.done, got.err, got.pos,
                     exp.ready, exp.pick, exp.place, exp.done, exp.err, exp.pos);
        end
    endtask

    task automatic checkCapture(input string name, input logic [3:0] exp);
        checks++;
        if (captured_code !== exp) begin
            fails++;
            $display("[TB] FAIL %s captured_code got %0h expected %0h", name, captured_code, exp);
        end
    endtask

    // Expected outputs k cycles after the handshake cycle (k=0).
    function automatic obs_t expTimeline(input int k, input logic [5:0] f, input logic [5:0] t,
                                         input logic err, input logic [5:0] lpos,
                                         input logic lpick, input logic lplace);
        obs_t e;
        e = '0;
        if (k == 0 || (err && k == 2)) begin
            e.ready = 1'b1;
            e.err   = (k == 2);
            e.pos   = lpos;
            e.pick  = lpick;
            e.place = lplace;
        end else if (err) begin
            e = '0;
        end else if (k == 2) begin
            e.pick = 1'b1;
            e.pos  = f;
        end else if (k >= 3 && k <= 2 + G) begin
            e.pos = f;
        end else if (k == 3 + G) begin
            e.place = 1'b1;
            e.pos   = t;
        end else if (k == 4 + G) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic runMove(input string name, input logic [5:0] f, input logic [5:0] t,
                           input logic expErr, input logic [3:0] expCap,
                           input logic nextValid, input logic [5:0] nextF, input logic [5:0] nextT,
                           input logic noise);
        int         last;
        logic [5:0] lpos;
        logic       lpick;
        logic       lplace;
        last = expErr ? 2 : 4 + G;
        for (int k = 0; k <= last; k++) begin
            lpos   = '0;
            lpick  = 1'b0;
            lplace = 1'b0;
            if (noise && k > 0 && !(expErr && k == 2)) begin
                lpos   = 6'($urandom_range(0, 63));
                lpick  = 1'($urandom_range(0, 1));
                lplace = 1'($urandom_range(0, 1));
            end
            if (k == 0) applyStimulus(1'b1, f, t, lpos, lpick, lplace);
            else        applyStimulus(nextValid, nextF, nextT, lpos, lpick, lplace);
            checkOutput(name, k, expTimeline(k, f, t, expErr, lpos, lpick, lplace));
        end
        checkCapture(name, expCap);
    endtask

    vec_t       vectors [6];
    logic [3:0] lastCap;
    logic [5:0] rf;
    logic [5:0] rt;
    logic       rErr;

    initial begin
        vectors[0] = '{"e2e4_quiet",   6'd52, 6'd36, 4'h1, 4'h0, 1'b0, 4'h0};
        vectors[1] = '{"capture_7",    6'd12, 6'd44, 4'h2, 4'h7, 1'b0, 4'h7};
        vectors[2] = '{"same_square",  6'd10, 6'd10, 4'h3, 4'h3, 1'b1, 4'h7};
        vectors[3] = '{"empty_source", 6'd20, 6'd28, 4'h0, 4'h5, 1'b1, 4'h7};
        vectors[4] = '{"corner_63_0",  6'd63, 6'd0,  4'hC, 4'hD, 1'b0, 4'hD};
        vectors[5] = '{"corner_0_63",  6'd0,  6'd63, 4'hD, 4'hC, 1'b0, 4'hC};

        rst         = 1'b0;
        move_valid  = 1'b0;
        move_from   = '0;
        move_to     = '0;
        local_pos   = '0;
        local_pick  = 1'b0;
        local_place = 1'b0;
        clearBoard();
        setBoard();
        #12;
        checkOutput("reset", 0, obs_t'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0}));
        checkCapture("reset", 4'h0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b0, 6'd0, 6'd0, 6'd33, 1'b1, 1'b0);
        checkOutput("pass_pick", 0, obs_t'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd33}));
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd5, 1'b0, 1'b1);
        checkOutput("pass_place", 0, obs_t'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5}));
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            clearBoard();
            boardModel[vectors[i].to]   = vectors[i].toCode;
            boardModel[vectors[i].from] = vectors[i].fromCode;
            setBoard();
            runMove(vectors[i].name, vectors[i].from, vectors[i].to, vectors[i].expErr,
                    vectors[i].expCap, 1'b0, ~vectors[i].from, ~vectors[i].to, (i % 2) == 1);
        end

        // Source keeps move_valid high with a second move queued behind the first.
        clearBoard();
        boardModel[8]  = 4'h2;
        boardModel[50] = 4'h9;
        boardModel[58] = 4'h3;
        setBoard();
        runMove("b2b_first",  6'd8,  6'd16, 1'b0, 4'h0, 1'b1, 6'd50, 6'd58, 1'b0);
        runMove("b2b_second", 6'd50, 6'd58, 1'b0, 4'h3, 1'b0, 6'd0,  6'd0,  1'b0);

        // Reset dropped in the middle of GAP must clear everything asynchronously.
        clearBoard();
        boardModel[40] = 4'h6;
        boardModel[41] = 4'h5;
        setBoard();
        applyStimulus(1'b1, 6'd40, 6'd41, 6'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        checkOutput("mid_gap", 3, obs_t'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd40}));
        checkCapture("mid_gap", 4'h5);
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 0, obs_t'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0}));
        checkCapture("async_reset", 4'h0);
        @(negedge clk);
        rst = 1'b1;
        runMove("after_reset", 6'd40, 6'd41, 1'b0, 4'h5, 1'b0, 6'd1, 6'd2, 1'b1);

        lastCap = 4'h5;
        for (int n = 0; n < 40; n++) begin
            for (int s = 0; s < 64; s++) begin
                boardModel[s] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 13));
            end
            setBoard();
            rf = 6'($urandom_range(0, 63));
            rt = ($urandom_range(0, 7) == 0) ? rf : 6'($urandom_range(0, 63));
            rErr = (rf == rt) || (boardModel[rf] == 4'h0);
            if (!rErr) lastCap = boardModel[rt];
            runMove("random", rf, rt, rErr, lastCap, 1'b0,
                    6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Initiator side of the chess_board pick/place command interface. It accepts one complete move (from square, to square) per handshake from the remote-move path (UART/opponent link or replay logic). It then drives the board with the same single-cycle pick_piece/place_piece pulses and figure_position that the mouse path uses. When idle it passes local mouse commands straight through, so one board instance serves both sources.

Parameters:
GAP_CYCLES, 1, idle cycles between the pick pulse and the place pulse (min 1, so the board latches the picked piece first).
SQ_W, 6, square address width: [5:3] row, [2:0] column.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
move_valid  in  1  remote move request
move_ready  out  1  sequencer can accept a move this cycle
move_from  in  SQ_W  source square
move_to  in  SQ_W  destination square
board_flat  in  256  board contents, square s at bits [4*s+3:4*s]; 0 = empty
local_pos  in  SQ_W  mouse square
local_pick  in  1  mouse pick request
local_place  in  1  mouse place request
figure_position  out  SQ_W  square address to chess_board
pick_piece  out  1  pick pulse to chess_board
place_piece  out  1  place pulse to chess_board
captured_code  out  4  code of the piece on move_to before placement (0 = none)
move_done  out  1  one-cycle pulse, move completed
move_err  out  1  one-cycle pulse, move rejected

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except move_ready=1; latched from/to = 0.
- States: IDLE, CHECK, PICK, GAP, PLACE, DONE.
- IDLE:
  - move_ready=1.
  - Outputs mirror local inputs combinationally: figure_position=local_pos, pick_piece=local_pick, place_piece=local_place.
  - Handshake: move_valid & move_ready on a rising edge latches from/to and goes to CHECK.
- CHECK (1 cycle, move_ready=0, local inputs ignored and pick/place forced 0):
  - If from==to or the source square is empty → move_err pulses next cycle, return to IDLE.
  - Otherwise register captured_code = code at the to square, then go to PICK.
- PICK (1 cycle): figure_position=from, pick_piece=1. Then GAP.
- GAP: figure_position=from, pick/place 0, counter runs GAP_CYCLES cycles, then PLACE.
- PLACE (1 cycle): figure_position=to, place_piece=1. Then DONE.
- DONE (1 cycle): move_done=1, outputs 0, then IDLE.
- Latency (no error): accept edge → done pulse = 4+GAP_CYCLES cycles. Pick is asserted 2 cycles after acceptance.
- Outside IDLE, local_pick/local_place are dropped, not queued. The move owns the board for its full duration.
- move_valid held high after done: a new move is accepted on the first IDLE cycle. Back-to-back moves are allowed, with no bubble beyond IDLE.
- Simultaneous local_pick and move_valid in IDLE: the local pulse passes through that cycle and the move is also accepted. Sources must not collide; the game FSM guarantees this. No arbitration is performed.
- captured_code holds its value until the next accepted move passes CHECK.
- Reset mid-move: immediate return to IDLE, pulses cleared. The board is reset by the same rst, so there is no partial-move recovery.
- The 6-bit addresses index the 64 squares directly; no wrap or clamp is needed.

Decomposition:
- Shared package (chess_pkg): piece code constants (EMPTY=0, white 1–6, black 7–C, HIGHLIGHT=D), square typedef (logic [5:0]), state enum for this sequencer.
- A small sub-module board_square_lookup (256-bit board + square → 4-bit code) is natural. It is reused for the source-empty check and the destination capture.

Test Plan:
- After reset, move 6,4→4,4 (from=52, to=36): pick_piece at cycle +2 with pos 52, place at +3+GAP with pos 36, move_done at +4+GAP, captured_code=0.
- Capture move onto a square holding 4'h7: captured_code=7, exactly one pick and one place pulse.
- from=to=10, or from on an empty square (e.g. 20): move_err one cycle after CHECK, no pick/place pulses, return to IDLE with move_ready=1.
- IDLE passthrough: local_pos=33 with local_pick for 1 cycle → pick_piece=1, figure_position=33 the same cycle. local_pick during GAP → pick_piece stays 0.
- move_valid held high with two queued moves: the second is accepted on the first IDLE cycle after done, and ordering is preserved.
- Drop rst to 0 during GAP: all outputs 0 and move_ready=1 immediately (asynchronously). Release rst, then a new move completes normally.
